// File: rtl/sprite_arb_pkg.sv
// Shared types and helpers for the sprite BROM arbiter: read-tag record,
// default BROM latencies and a one-hot decoder.
package sprite_arb_pkg;

    localparam int READ_LATENCY_HP = 2;
    localparam int READ_LATENCY_LL = 1;

    // Tag ids are sized for the largest supported requester count (8).
    localparam int MAX_REQ  = 8;
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic logic [MAX_REQ-1:0] onehot_from_index(
        input logic [TAG_ID_W-1:0] idx,
        input logic                en
    );
        logic [MAX_REQ-1:0] oh;
        oh = '0;
        if (en) oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid_in at or after
// ptr_in (wrapping), returned both one-hot and as an index.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_in,
    input  logic [PTR_W-1:0] ptr_in,
    output logic [N-1:0]     grant_out,
    output logic [PTR_W-1:0] idx_out,
    output logic             any_out
);

    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
        grant_out = '0;
        idx_out   = '0;
        any_out   = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand     = (int'(ptr_in) + k) % N;
            cand_idx = cand[PTR_W-1:0];
            if (!any_out && valid_in[cand_idx]) begin
                grant_out[cand_idx] = 1'b1;
                idx_out             = cand_idx;
                any_out             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite BROM read port; tags each read through
// the BROM latency. Define SPRITE_ARB_PRIORITY_EN to make requester 0 fixed-priority.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = READ_LATENCY_HP
) (
    input  logic                               pixel_clk_in,
    input  logic                               rst_n_in,
    input  logic [NUM_REQ-1:0]                 req_valid_in,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_in,
    output logic [NUM_REQ-1:0]                 req_ready_out,
    output logic [ADDR_WIDTH-1:0]              rom_addr_out,
    output logic                               rom_en_out,
    input  logic [DATA_WIDTH-1:0]              rom_data_in,
    output logic [NUM_REQ-1:0]                 rsp_valid_out,
    output logic [DATA_WIDTH-1:0]              rsp_data_out
);

    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]    pick_valid;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [ID_W-1:0]       pick_idx;
    logic                  pick_any;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_any;

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  rom_en_q, rom_en_d;
    tag_t                  tag_q [READ_LATENCY+1];
    tag_t                  tag_d [READ_LATENCY+1];

`ifdef SPRITE_ARB_PRIORITY_EN
    // Requester 0 bypasses the ring; the picker only sees 1..NUM_REQ-1.
    assign pick_valid = {req_valid_in[NUM_REQ-1:1], 1'b0};
`else
    assign pick_valid = req_valid_in;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_rr_pick (
        .valid_in  (pick_valid),
        .ptr_in    (ptr_q),
        .grant_out (pick_grant),
        .idx_out   (pick_idx),
        .any_out   (pick_any)
    );

    always_comb begin
        grant     = pick_grant;
        grant_idx = pick_idx;
        grant_any = pick_any;
`ifdef SPRITE_ARB_PRIORITY_EN
        if (req_valid_in[0]) begin
            grant     = NUM_REQ'(1);
            grant_idx = '0;
            grant_any = 1'b1;
        end
`endif
    end

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        rom_en_d   = grant_any;
        if (grant_any) begin
            rom_addr_d = req_addr_in[grant_idx];
`ifdef SPRITE_ARB_PRIORITY_EN
            // The pointer rings over 1..NUM_REQ-1 and ignores grants to requester 0.
            if (grant_idx != '0) begin
                ptr_d = (grant_idx == LAST_ID) ? ID_W'(1) : grant_idx + ID_W'(1);
            end
`else
            ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
`endif
        end
        tag_d[0] = '{valid: grant_any, id: TAG_ID_W'(grant_idx)};
        for (int k = 1; k <= READ_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        // NOTE: state updates use non-blocking assignments; the tag pipeline is reset too, so a reset drops every in-flight read.
        if (!rst_n_in) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            for (int k = 0; k <= READ_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            rom_en_q   <= rom_en_d;
            for (int k = 0; k <= READ_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign req_ready_out = grant;
    assign rom_addr_out  = rom_addr_q;
    assign rom_en_out    = rom_en_q;
    assign rsp_valid_out = NUM_REQ'(onehot_from_index(tag_q[READ_LATENCY].id, tag_q[READ_LATENCY].valid));
    assign rsp_data_out  = rom_data_in;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: table vectors, hand-written
// corner sequences and a random phase against a queue-based reference model.
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0][AW-1:0] req_addr = '0;
    logic [N-1:0]         req_ready;
    logic [AW-1:0]        rom_addr;
    logic                 rom_en;
    logic [DW-1:0]        rom_data = '0;
    logic [DW-1:0]        rom_stage = '0;
    logic [N-1:0]         rsp_valid;
    logic [DW-1:0]        rsp_data;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(
        .NUM_REQ      (N),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (2)
    ) dut (
        .pixel_clk_in  (clk),
        .rst_n_in      (rst_n),
        .req_valid_in  (req_valid),
        .req_addr_in   (req_addr),
        .req_ready_out (req_ready),
        .rom_addr_out  (rom_addr),
        .rom_en_out    (rom_en),
        .rom_data_in   (rom_data),
        .rsp_valid_out (rsp_valid),
        .rsp_data_out  (rsp_data)
    );

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Two-cycle BROM: address seen in cycle t returns data in cycle t+2.
    always @(posedge clk) begin
        rom_stage <= rom_f(rom_addr);
        rom_data  <= rom_stage;
    end

    typedef struct {
        int            due;
        int            id;
        logic [AW-1:0] addr;
    } pend_t;

    typedef struct {
        int           prev;
        logic [N-1:0] valid;
        logic [N-1:0] exp;
    } vec_t;

    pend_t         q[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            m_ptr = 0;
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [N-1:0]  obs_ready;
    logic          obs_en;
    logic [AW-1:0] obs_addr;
    logic [N-1:0]  obs_rsp;
    logic [DW-1:0] obs_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Winner = valid requester with the smallest ring distance from the pointer.
    function automatic int model_pick(input logic [N-1:0] v);
        int best  = -1;
        int bestd = N;
        int d;
`ifdef SPRITE_ARB_PRIORITY_EN
        if (v[0]) return 0;
        for (int i = 1; i < N; i++) begin
            if (v[i]) begin
                d = (i - m_ptr + (N - 1)) % (N - 1);
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
`endif
        return best;
    endfunction

    task automatic model_reset();
        q.delete();
        m_en   = 1'b0;
        m_addr = '0;
`ifdef SPRITE_ARB_PRIORITY_EN
        m_ptr = 1;
`else
        m_ptr = 0;
`endif
    endtask

    // One clock cycle: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int            g;
        logic [N-1:0]  er;
        logic [N-1:0]  ersp;
        logic [DW-1:0] edata;
        pend_t         e;
        @(negedge clk);
        g     = model_pick(req_valid);
        er    = (g >= 0) ? (N'(1) << g) : '0;
        ersp  = '0;
        edata = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e     = q.pop_front();
            ersp  = N'(1) << e.id;
            edata = rom_f(e.addr);
        end
        obs_ready = req_ready;
        obs_en    = rom_en;
        obs_addr  = rom_addr;
        obs_rsp   = rsp_valid;
        obs_data  = rsp_data;
        check("req_ready", 32'(req_ready), 32'(er));
        check("rom_en", 32'(rom_en), 32'(m_en));
        check("rom_addr", 32'(rom_addr), 32'(m_addr));
        check("rsp_valid", 32'(rsp_valid), 32'(ersp));
        if (ersp != '0) check("rsp_data", 32'(rsp_data), 32'(edata));
        @(posedge clk);
        if (rst_n) begin
            if (g >= 0) begin
                m_en   = 1'b1;
                m_addr = req_addr[g];
                e.due  = cyc + 3;
                e.id   = g;
                e.addr = req_addr[g];
                q.push_back(e);
`ifdef SPRITE_ARB_PRIORITY_EN
                if (g != 0) m_ptr = g % (N - 1) + 1;
`else
                m_ptr = (g + 1) % N;
`endif
            end else begin
                m_en = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic reset_pulse();
        rst_n     = 1'b0;
        req_valid = '0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    vec_t          tbl[7];
    logic [N-1:0]  pend;
    int            age[N];
    int            exp4[4];

    initial begin
`ifdef SPRITE_ARB_PRIORITY_EN
        tbl[0] = '{3, 4'b1001, 4'b0001};
        tbl[1] = '{1, 4'b1110, 4'b0100};
        tbl[2] = '{3, 4'b1100, 4'b0100};
        tbl[3] = '{2, 4'b0010, 4'b0010};
        tbl[4] = '{2, 4'b0000, 4'b0000};
        tbl[5] = '{2, 4'b0111, 4'b0001};
        tbl[6] = '{3, 4'b1000, 4'b1000};
`else
        tbl[0] = '{3, 4'b1001, 4'b0001};
        tbl[1] = '{0, 4'b0001, 4'b0001};
        tbl[2] = '{1, 4'b0011, 4'b0001};
        tbl[3] = '{2, 4'b0110, 4'b0010};
        tbl[4] = '{1, 4'b1111, 4'b0100};
        tbl[5] = '{2, 4'b0000, 4'b0000};
        tbl[6] = '{3, 4'b1110, 4'b0010};
`endif
        exp4 = '{1, 2, 3, 1};

        model_reset();
        tick();
        rst_n = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_rom_en", 32'(obs_en), 32'(0));
            check("idle_rom_addr", 32'(obs_addr), 32'(0));
            check("idle_rsp_valid", 32'(obs_rsp), 32'(0));
        end

        // Single request from requester 2 and its three-cycle round trip.
        req_addr[2]  = 16'h0123;
        req_valid    = 4'b0100;
        tick();
        check("single_ready", 32'(obs_ready), 32'(4'b0100));
        req_valid = '0;
        tick();
        check("single_rom_en", 32'(obs_en), 32'(1));
        check("single_rom_addr", 32'(obs_addr), 32'(16'h0123));
        tick();
        check("single_rsp_early", 32'(obs_rsp), 32'(0));
        tick();
        check("single_rsp_valid", 32'(obs_rsp), 32'(4'b0100));
        check("single_rsp_data", 32'(obs_data), 32'(rom_f(16'h0123)));

        // All four valid continuously from a fresh pointer.
        reset_pulse();
        for (int i = 0; i < N; i++) req_addr[i] = AW'(16'h0010 * i);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
`ifdef SPRITE_ARB_PRIORITY_EN
            check("all_valid_grant", 32'(obs_ready), 32'(4'b0001));
`else
            check("all_valid_grant", 32'(obs_ready), 32'(N'(1) << (k % N)));
`endif
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();

        // Requester 0 idle: the others rotate 1,2,3,1.
        req_valid = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_req0_grant", 32'(obs_ready), 32'(N'(1) << exp4[k]));
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();

        // Reset mid-flight drops in-flight tags and returns the pointer to its start.
        reset_pulse();
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) tick();
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("flush_no_rsp", 32'(obs_rsp), 32'(0));
        end
        req_valid = 4'b1010;
        tick();
        check("post_reset_grant", 32'(obs_ready), 32'(4'b0010));
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();

        // Table vectors: a setup grant to 'prev' positions the pointer.
        for (int r = 0; r < 7; r++) begin
            req_addr  = '0;
            req_valid = N'(1) << tbl[r].prev;
            req_addr[tbl[r].prev] = AW'($urandom);
            tick();
            for (int i = 0; i < N; i++) req_addr[i] = AW'($urandom);
            req_valid = tbl[r].valid;
            tick();
            check("tbl_ready", 32'(obs_ready), 32'(tbl[r].exp));
            req_valid = '0;
        end
        for (int k = 0; k < 4; k++) tick();

        // Random traffic; requesters hold valid and address until granted.
        pend = '0;
        for (int i = 0; i < N; i++) age[i] = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                reset_pulse();
                pend = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]     = 1'b1;
                    req_addr[i] = AW'($urandom);
                    age[i]      = 0;
                end
            end
            req_valid = pend;
            tick();
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if (obs_ready[i]) begin
`ifndef SPRITE_ARB_PRIORITY_EN
                        check("fair_wait", 32'(age[i] < N), 32'(1));
`endif
                        pend[i] = 1'b0;
                    end else begin
                        age[i]++;
                    end
                end
            end
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++) tick();
        check("queue_drained", 32'(q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
